// File: rtl/axi_burst_tracker.sv
// Tracks outstanding AXI bursts by ID and hands out the current beat of the
// oldest burst per ID, advancing its address per FIXED/INCR/WRAP rules.
module axi_burst_tracker #(
    parameter int NumEntries = 8,
    parameter int IdWidth    = 4,
    parameter int AddrWidth  = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            alloc_req_i,
    output logic                            alloc_gnt_o,
    input  logic [IdWidth-1:0]              alloc_id_i,
    input  logic [AddrWidth-1:0]            alloc_addr_i,
    input  logic [7:0]                      alloc_len_i,
    input  logic [2:0]                      alloc_size_i,
    input  logic [1:0]                      alloc_burst_i,
    input  logic                            cnt_req_i,
    output logic                            cnt_gnt_o,
    input  logic [IdWidth-1:0]              cnt_id_i,
    output logic [7:0]                      cnt_len_o,
    output logic [AddrWidth-1:0]            cnt_addr_o,
    output logic                            cnt_last_o,
    output logic                            cnt_err_o,
    input  logic                            cnt_next_i,
    input  logic                            cnt_set_err_i,
    output logic [$clog2(NumEntries+1)-1:0] occupancy_o
);
    localparam int OccW = $clog2(NumEntries + 1);

    logic [NumEntries-1:0] w_valid, w_err, w_alloc_sel, w_match, w_head, w_clear_col;
    logic [NumEntries-1:0] w_older [NumEntries];
    logic [IdWidth-1:0]    w_id [NumEntries];
    logic [AddrWidth-1:0]  w_addr [NumEntries];
    logic [7:0]            w_len [NumEntries];
    logic [7:0]            w_len_orig [NumEntries];
    logic [2:0]            w_size [NumEntries];
    logic [1:0]            w_burst [NumEntries];

    logic                 w_alloc_fire, w_alloc_err, w_next_fire, w_free_fire, w_err_fire;
    logic [1:0]           w_alloc_burst;
    logic [AddrWidth-1:0] w_h_addr, w_next_addr, w_step, w_wrap_bytes;
    logic [7:0]           w_h_len, w_h_len_orig;
    logic [2:0]           w_h_size;
    logic [1:0]           w_h_burst;
    logic                 w_h_err;
    logic [OccW-1:0]      r_occ;

    // Lowest invalid entry, taken only from state at the start of the cycle.
    assign w_alloc_sel  = ~w_valid & (w_valid + NumEntries'(1));
    assign alloc_gnt_o  = ~&w_valid;
    assign w_alloc_fire = alloc_req_i & alloc_gnt_o;

    assign w_alloc_err = (alloc_burst_i == 2'b11) ||
                         ((alloc_burst_i == 2'b10) && !((alloc_len_i == 8'd1) || (alloc_len_i == 8'd3) ||
                                                         (alloc_len_i == 8'd7) || (alloc_len_i == 8'd15)));
    assign w_alloc_burst = w_alloc_err ? 2'b01 : alloc_burst_i;

    always_comb begin
        w_h_addr     = '0;
        w_h_len      = '0;
        w_h_len_orig = '0;
        w_h_size     = '0;
        w_h_burst    = '0;
        w_h_err      = 1'b0;
        for (int i = 0; i < NumEntries; i++) begin
            if (w_head[i]) begin
                w_h_addr     = w_addr[i];
                w_h_len      = w_len[i];
                w_h_len_orig = w_len_orig[i];
                w_h_size     = w_size[i];
                w_h_burst    = w_burst[i];
                w_h_err      = w_err[i];
            end
        end
    end

    assign cnt_gnt_o   = cnt_req_i & (|w_head);
    assign cnt_len_o   = w_h_len;
    assign cnt_addr_o  = w_h_addr;
    assign cnt_last_o  = (w_h_len == 8'd0);
    assign cnt_err_o   = w_h_err | (cnt_gnt_o & cnt_set_err_i);
    assign w_next_fire = cnt_gnt_o & cnt_next_i;
    assign w_free_fire = w_next_fire & cnt_last_o;
    assign w_err_fire  = cnt_gnt_o & cnt_set_err_i;

    assign w_step       = AddrWidth'(1) << w_h_size;
    assign w_wrap_bytes = AddrWidth'({1'b0, w_h_len_orig} + 9'd1) << w_h_size;

    always_comb begin
        case (w_h_burst)
            2'b00:   w_next_addr = w_h_addr;
            2'b10:   w_next_addr = (w_h_addr & ~(w_wrap_bytes - AddrWidth'(1))) |
                                   ((w_h_addr + w_step) & (w_wrap_bytes - AddrWidth'(1)));
            default: w_next_addr = (w_h_addr & ~(w_step - AddrWidth'(1))) + w_step;
        endcase
    end

    // Columns cleared here drop the allocated/freed entry from everyone's "older" set.
    assign w_clear_col = (w_alloc_fire ? w_alloc_sel : '0) | (w_free_fire ? w_head : '0);

    generate
        for (genvar gi = 0; gi < NumEntries; gi++) begin : g_entry
            logic                  r_valid, r_err;
            logic [IdWidth-1:0]    r_id;
            logic [AddrWidth-1:0]  r_addr;
            logic [7:0]            r_len, r_len_orig;
            logic [2:0]            r_size;
            logic [1:0]            r_burst;
            logic [NumEntries-1:0] r_older;

            assign w_valid[gi]    = r_valid;
            assign w_err[gi]      = r_err;
            assign w_id[gi]       = r_id;
            assign w_addr[gi]     = r_addr;
            assign w_len[gi]      = r_len;
            assign w_len_orig[gi] = r_len_orig;
            assign w_size[gi]     = r_size;
            assign w_burst[gi]    = r_burst;
            assign w_older[gi]    = r_older;
            assign w_match[gi]    = r_valid && (r_id == cnt_id_i);
            assign w_head[gi]     = w_match[gi] && !(|(w_match & r_older));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    r_older <= '0;
                end else if (w_alloc_fire && w_alloc_sel[gi]) begin
                    r_valid    <= 1'b1;
                    r_err      <= w_alloc_err;
                    r_id       <= alloc_id_i;
                    r_addr     <= alloc_addr_i;
                    r_len      <= alloc_len_i;
                    r_len_orig <= alloc_len_i;
                    r_size     <= alloc_size_i;
                    r_burst    <= w_alloc_burst;
                    r_older    <= w_valid & ~w_clear_col;
                end else begin
                    r_older <= r_older & ~w_clear_col;
                    if (w_head[gi] && w_next_fire) begin
                        if (r_len == 8'd0) begin
                            r_valid <= 1'b0;
                        end else begin
                            r_len  <= r_len - 8'd1;
                            r_addr <= w_next_addr;
                        end
                    end
                    if (w_head[gi] && w_err_fire) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_occ <= '0;
        end else if (w_alloc_fire && !w_free_fire) begin
            r_occ <= r_occ + OccW'(1);
        end else if (!w_alloc_fire && w_free_fire) begin
            r_occ <= r_occ - OccW'(1);
        end
    end

    assign occupancy_o = r_occ;

endmodule

// File: tb/tb_axi_burst_tracker.sv
// Directed bench for axi_burst_tracker: INCR/WRAP addressing, per-ID order,
// full/free behaviour, error marking and reset flush.
module tb_axi_burst_tracker;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alloc_req_i;
    logic        alloc_gnt_o;
    logic [3:0]  alloc_id_i;
    logic [31:0] alloc_addr_i;
    logic [7:0]  alloc_len_i;
    logic [2:0]  alloc_size_i;
    logic [1:0]  alloc_burst_i;
    logic        cnt_req_i;
    logic        cnt_gnt_o;
    logic [3:0]  cnt_id_i;
    logic [7:0]  cnt_len_o;
    logic [31:0] cnt_addr_o;
    logic        cnt_last_o;
    logic        cnt_err_o;
    logic        cnt_next_i;
    logic        cnt_set_err_i;
    logic [3:0]  occupancy_o;

    int checks = 0;
    int errors = 0;

    axi_burst_tracker dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_id_i(alloc_id_i),
        .alloc_addr_i(alloc_addr_i), .alloc_len_i(alloc_len_i), .alloc_size_i(alloc_size_i),
        .alloc_burst_i(alloc_burst_i),
        .cnt_req_i(cnt_req_i), .cnt_gnt_o(cnt_gnt_o), .cnt_id_i(cnt_id_i), .cnt_len_o(cnt_len_o),
        .cnt_addr_o(cnt_addr_o), .cnt_last_o(cnt_last_o), .cnt_err_o(cnt_err_o),
        .cnt_next_i(cnt_next_i), .cnt_set_err_i(cnt_set_err_i), .occupancy_o(occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alloc(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        alloc_id_i = id; alloc_addr_i = addr; alloc_len_i = len;
        alloc_size_i = size; alloc_burst_i = burst; alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
    endtask

    // Look up id and check the head beat; consume it when nxt is set.
    task automatic beat(input string tag, input logic [3:0] id, input logic [31:0] addr,
                        input logic last, input logic err, input logic nxt);
        cnt_id_i = id; cnt_req_i = 1'b1; cnt_next_i = nxt;
        #1;
        chk({tag, "_gnt"}, 64'(cnt_gnt_o), 64'd1);
        chk({tag, "_addr"}, 64'(cnt_addr_o), 64'(addr));
        chk({tag, "_last"}, 64'(cnt_last_o), 64'(last));
        chk({tag, "_err"}, 64'(cnt_err_o), 64'(err));
        tick();
        cnt_req_i = 1'b0; cnt_next_i = 1'b0;
    endtask

    task automatic miss(input string tag, input logic [3:0] id);
        cnt_id_i = id; cnt_req_i = 1'b1;
        #1;
        chk(tag, 64'(cnt_gnt_o), 64'd0);
        cnt_req_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; alloc_req_i = 0; alloc_id_i = 0; alloc_addr_i = 0; alloc_len_i = 0;
        alloc_size_i = 0; alloc_burst_i = 0; cnt_req_i = 0; cnt_id_i = 0;
        cnt_next_i = 0; cnt_set_err_i = 0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_occ", 64'(occupancy_o), 64'd0);
        chk("rst_gnt", 64'(alloc_gnt_o), 64'd1);
        miss("rst_lookup", 4'd3);

        // INCR, with a same-cycle lookup that must not see the new entry
        alloc_id_i = 4'd3; alloc_addr_i = 32'h1002; alloc_len_i = 8'd3;
        alloc_size_i = 3'd2; alloc_burst_i = 2'b01; alloc_req_i = 1'b1;
        miss("incr_same_cycle", 4'd3);
        tick();
        alloc_req_i = 1'b0;
        chk("incr_occ", 64'(occupancy_o), 64'd1);
        cnt_id_i = 4'd3; cnt_req_i = 1'b1; #1;
        chk("incr_len", 64'(cnt_len_o), 64'd3);
        beat("incr0", 4'd3, 32'h1002, 1'b0, 1'b0, 1'b1);
        beat("incr1", 4'd3, 32'h1004, 1'b0, 1'b0, 1'b1);
        beat("incr2", 4'd3, 32'h1008, 1'b0, 1'b0, 1'b1);
        beat("incr3", 4'd3, 32'h100C, 1'b1, 1'b0, 1'b1);
        chk("incr_occ_end", 64'(occupancy_o), 64'd0);
        miss("incr_gone", 4'd3);

        // WRAP 4 beats x 8 bytes starting mid-window
        alloc(4'd7, 32'h38, 8'd3, 3'd3, 2'b10);
        beat("wrap0", 4'd7, 32'h38, 1'b0, 1'b0, 1'b1);
        beat("wrap1", 4'd7, 32'h20, 1'b0, 1'b0, 1'b1);
        beat("wrap2", 4'd7, 32'h28, 1'b0, 1'b0, 1'b1);
        beat("wrap3", 4'd7, 32'h30, 1'b1, 1'b0, 1'b1);

        // Per-ID ordering
        alloc(4'd1, 32'h100, 8'd0, 3'd0, 2'b01);
        alloc(4'd2, 32'h200, 8'd1, 3'd0, 2'b01);
        alloc(4'd1, 32'h300, 8'd0, 3'd0, 2'b01);
        chk("ord_occ", 64'(occupancy_o), 64'd3);
        beat("ord_b_peek", 4'd2, 32'h200, 1'b0, 1'b0, 1'b0);
        beat("ord_a", 4'd1, 32'h100, 1'b1, 1'b0, 1'b1);
        beat("ord_b_peek2", 4'd2, 32'h200, 1'b0, 1'b0, 1'b0);
        beat("ord_c", 4'd1, 32'h300, 1'b1, 1'b0, 1'b1);
        beat("ord_b0", 4'd2, 32'h200, 1'b0, 1'b0, 1'b1);
        beat("ord_b1", 4'd2, 32'h201, 1'b1, 1'b0, 1'b1);
        chk("ord_occ_end", 64'(occupancy_o), 64'd0);

        // Fill, then free one while requesting an allocation in the same cycle
        for (int i = 0; i < 8; i++) alloc(4'(i), 32'(i * 16), 8'd0, 3'd0, 2'b01);
        chk("full_gnt", 64'(alloc_gnt_o), 64'd0);
        chk("full_occ", 64'(occupancy_o), 64'd8);
        alloc_id_i = 4'd9; alloc_addr_i = 32'h999; alloc_len_i = 8'd0;
        alloc_size_i = 3'd0; alloc_burst_i = 2'b01; alloc_req_i = 1'b1;
        cnt_id_i = 4'd5; cnt_req_i = 1'b1; cnt_next_i = 1'b1; #1;
        chk("full_free_same_gnt", 64'(alloc_gnt_o), 64'd0);
        tick();
        cnt_req_i = 1'b0; cnt_next_i = 1'b0;
        chk("full_after_free_gnt", 64'(alloc_gnt_o), 64'd1);
        chk("full_after_free_occ", 64'(occupancy_o), 64'd7);
        tick();
        alloc_req_i = 1'b0;
        chk("full_realloc_gnt", 64'(alloc_gnt_o), 64'd0);
        chk("full_realloc_occ", 64'(occupancy_o), 64'd8);
        beat("full_id9", 4'd9, 32'h999, 1'b1, 1'b0, 1'b1);
        chk("full_free9_occ", 64'(occupancy_o), 64'd7);
        alloc_id_i = 4'd10; alloc_addr_i = 32'hA00; alloc_req_i = 1'b1;
        cnt_id_i = 4'd1; cnt_req_i = 1'b1; cnt_next_i = 1'b1;
        tick();
        alloc_req_i = 1'b0; cnt_req_i = 1'b0; cnt_next_i = 1'b0;
        chk("simul_occ", 64'(occupancy_o), 64'd7);
        beat("simul_id10", 4'd10, 32'hA00, 1'b1, 1'b0, 1'b0);
        miss("simul_id1_gone", 4'd1);

        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("mid_rst_occ", 64'(occupancy_o), 64'd0);

        // Errors: illegal WRAP length behaves as INCR with err set
        alloc(4'd4, 32'h40, 8'd2, 3'd2, 2'b10);
        beat("werr0", 4'd4, 32'h40, 1'b0, 1'b1, 1'b1);
        beat("werr1", 4'd4, 32'h44, 1'b0, 1'b1, 1'b1);
        beat("werr2", 4'd4, 32'h48, 1'b1, 1'b1, 1'b1);
        alloc(4'd5, 32'h50, 8'd0, 3'd0, 2'b11);
        beat("burst3", 4'd5, 32'h50, 1'b1, 1'b1, 1'b1);
        alloc(4'd6, 32'h80, 8'd1, 3'd0, 2'b01);
        cnt_id_i = 4'd6; cnt_req_i = 1'b1; #1;
        chk("clean_err_before", 64'(cnt_err_o), 64'd0);
        cnt_set_err_i = 1'b1; #1;
        chk("set_err_same", 64'(cnt_err_o), 64'd1);
        tick();
        cnt_set_err_i = 1'b0;
        beat("set_err0", 4'd6, 32'h80, 1'b0, 1'b1, 1'b1);
        beat("set_err1", 4'd6, 32'h81, 1'b1, 1'b1, 1'b1);
        alloc(4'd6, 32'h90, 8'd0, 3'd0, 2'b01);
        beat("reuse_clean", 4'd6, 32'h90, 1'b1, 1'b0, 1'b1);

        // Reset with five entries in flight
        for (int i = 0; i < 5; i++) alloc(4'(i + 1), 32'(i * 256), 8'd3, 3'd0, 2'b01);
        chk("pre_rst_occ", 64'(occupancy_o), 64'd5);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("post_rst_occ", 64'(occupancy_o), 64'd0);
        chk("post_rst_gnt", 64'(alloc_gnt_o), 64'd1);
        for (int i = 1; i <= 5; i++) miss("post_rst_lookup", 4'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_burst_tracker.md
AXI_BURST_TRACKER -- requirements
Module: axi_burst_tracker

Interface
REQ-001 SHALL have parameter NumEntries, default 8: number of outstanding bursts tracked; legal values are 1 to 64.
REQ-002 SHALL have parameter IdWidth, default 4: width of the AXI ID.
REQ-003 SHALL have parameter AddrWidth, default 32: width of the beat address.
REQ-004 SHALL have ports, in order:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous and active-high.
- alloc_req_i  in  1  request to allocate a burst.
- alloc_gnt_o  out  1  allocation accepted.
- alloc_id_i  in  IdWidth  ID of the burst.
- alloc_addr_i  in  AddrWidth  start address.
- alloc_len_i  in  8  AXI len (beats-1).
- alloc_size_i  in  3  AXI size.
- alloc_burst_i  in  2  AXI burst type.
- cnt_req_i  in  1  lookup request.
- cnt_gnt_o  out  1  lookup hit.
- cnt_id_i  in  IdWidth  lookup ID.
- cnt_len_o  out  8  remaining beats-1.
- cnt_addr_o  out  AddrWidth  current beat address.
- cnt_last_o  out  1  current beat is the last.
- cnt_err_o  out  1  sticky error of the entry.
- cnt_next_i  in  1  consume the current beat.
- cnt_set_err_i  in  1  mark the entry erroneous.
- occupancy_o  out  $clog2(NumEntries+1)  number of valid entries.

Function
REQ-005 SHALL keep the following state per entry: valid, id, addr, len, size, burst, err, plus an age matrix older[i][j].
REQ-006 SHALL assert alloc_gnt_o combinationally when at least one entry is invalid, independent of alloc_req_i.
REQ-007 SHALL write the lowest-index invalid entry on alloc_req_i&alloc_gnt_o, and SHALL mark it younger than every valid entry.
REQ-008 SHALL select a free entry only from entries that were invalid at the start of the cycle; an entry freed in the same cycle is not reusable until the next cycle.
REQ-009 SHALL make an allocated entry visible to lookup one cycle after the grant; a same-cycle lookup SHALL NOT see it.
REQ-010 SHALL define the head for an ID as the valid entry with a matching id that has no older valid entry with the same id.
REQ-011 SHALL drive cnt_gnt_o = cnt_req_i & (a head exists for cnt_id_i), and SHALL drive the cnt_* outputs from that head; outputs are don't-care when cnt_gnt_o=0.
REQ-012 SHALL drive cnt_last_o = (cnt_len_o == 0).
REQ-013 SHALL, on cnt_gnt_o&cnt_next_i with a non-last beat, decrement len and advance addr per REQ-014..016.
REQ-014 SHALL leave the address unchanged for FIXED (2'b00).
REQ-015 SHALL compute the next address for INCR (2'b01) as (addr & ~(2^size-1)) + 2^size, modulo 2^AddrWidth.
REQ-016 SHALL compute the next address for WRAP (2'b10) with W=(len_orig+1)<<size as (addr & ~(W-1)) | ((addr+2^size) & (W-1)); the entry keeps len_orig for this purpose.
REQ-017 SHALL, on cnt_gnt_o&cnt_next_i with the last beat, clear valid and update the age matrix.
REQ-018 SHALL, on cnt_gnt_o&cnt_set_err_i, set err and drive cnt_err_o=1 in the same cycle.
REQ-019 SHALL set err at allocation when burst=2'b11, or when burst is WRAP with len not in {1,3,7,15}; such an entry SHALL still track len but SHALL behave as INCR for addressing.
REQ-020 SHALL update occupancy_o one cycle after each alloc or free; with a simultaneous alloc and free it SHALL stay unchanged.
REQ-021 SHALL have no combinational path from the alloc_* inputs to the cnt_* outputs.

Reset
REQ-022 SHALL, while rst_i=1 at a clock edge, clear all valid bits, err bits and the age matrix, so that after reset occupancy_o=0, alloc_gnt_o=1 and cnt_gnt_o=0.
REQ-023 SHALL discard any in-flight bursts when reset is asserted mid-operation; no entry survives.

Verification
REQ-024 SHALL verify INCR: alloc id=3, addr=0x1002, len=3, size=2 -> beats 0x1002, 0x1004, 0x1008, 0x100C, with last on the fourth beat, then occupancy_o=0.
REQ-025 SHALL verify WRAP: alloc addr=0x38, len=3, size=3 -> beats 0x38, 0x20, 0x28, 0x30, and err=0.
REQ-026 SHALL verify per-ID ordering: alloc A(id=1,len=0), B(id=2), C(id=1) -> id=1 lookups hit A then C, and id=2 hits B at any time.
REQ-027 SHALL verify full: NumEntries allocs -> alloc_gnt_o=0; a last beat frees an entry -> alloc_gnt_o=1 next cycle, and the next alloc uses the freed index.
REQ-028 SHALL verify errors: alloc burst=2'b10 with len=2 -> cnt_err_o=1 on every beat; cnt_set_err_i on beat 0 of a clean burst -> err=1 in that cycle and stays set until the entry is freed.
REQ-029 SHALL verify reset: rst_i asserted with 5 valid entries -> next cycle occupancy_o=0, and a lookup of any ID returns cnt_gnt_o=0.
